// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator in front of a synchronous MainMemory (one-cycle
// read latency). It owns the MAR/MBR and serves single-word writes and
// 1..16 word burst reads.
//
// Optional range checking is enabled by defining MAU_BOUNDS_CHECK_EN. When it
// is undefined, no check is made, rsp_err is tied low and ERR cannot be reached.
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both high. Once raised, rsp_valid and the response
// fields hold until that transfer. req_ready is high only in IDLE.
//
// dbg_state exposes the FSM state for checkers and debug. It takes no part in
// the datapath.
module mem_access_unit #(
  parameter int MEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    RD_RESP    = 3'd3,
    WR         = 3'd4,
    WR_ACK     = 3'd5,
    ERR        = 3'd6
  } state_t;

`ifdef MAU_BOUNDS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t      state, state_next;
  logic [15:0] mar, mar_next;
  logic [15:0] mbr, mbr_next;
  logic [3:0]  cnt, cnt_next;
  logic        we_raw;
  logic [16:0] rd_end;
  logic        range_err;
  logic        req_err;

  // The sum is 17 bits wide, so a burst that runs past 16'hFFFF is still
  // seen as out of range instead of wrapping to a small value.
  assign rd_end    = {1'b0, req_addr} + {13'd0, req_len};
  assign range_err = req_write ? ({1'b0, req_addr} >= 17'(MEM_WORDS))
                               : (rd_end >= 17'(MEM_WORDS));
  assign req_err   = CHECK_EN && range_err;

  // State, MAR, MBR and the word counter all update on the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mar   <= 16'h0000;
      mbr   <= 16'h0000;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      mar   <= mar_next;
      mbr   <= mbr_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and output decode. Every output gets a default first.
  always_comb begin
    state_next = state;
    mar_next   = mar;
    mbr_next   = mbr;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    rsp_data   = mbr;
    we_raw     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mar_next = req_addr;
          if (req_err) begin
            state_next = ERR;
          end else if (req_write) begin
            mbr_next   = req_wdata;
            state_next = WR;
          end else begin
            cnt_next   = req_len;
            state_next = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        state_next = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        mbr_next   = mem_rdata;
        mar_next   = mar + 16'd1;
        state_next = RD_RESP;
      end
      RD_RESP: begin
        rsp_valid = 1'b1;
        rsp_last  = (cnt == 4'd0);
        if (rsp_ready) begin
          if (cnt == 4'd0) begin
            state_next = IDLE;
          end else begin
            cnt_next   = cnt - 4'd1;
            state_next = RD_ISSUE;
          end
        end
      end
      WR: begin
        we_raw     = 1'b1;
        state_next = WR_ACK;
      end
      WR_ACK: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        rsp_data  = 16'h0000;
        if (rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reset gates the strobe directly, so a reset in the WR cycle drops the
  // write before memory can commit it.
  assign mem_we    = we_raw && !reset;
  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign dbg_state = state;

`ifdef MAU_BOUNDS_CHECK_EN
  assign rsp_err = (state == ERR);
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It models MainMemory and keeps a separate
// reference memory. Expected responses come from address arithmetic on that
// reference memory. Build with or without +define+MAU_BOUNDS_CHECK_EN.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 16384;
`ifdef MAU_BOUNDS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [3:0]  req_len = 4'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // MainMemory model: 16Ki x 16, synchronous, one-cycle read latency.
  logic [15:0] mem [MEM_WORDS];
  logic        mem_clear = 1'b1;

  function automatic int idx(input logic [15:0] a);
    return int'(a) % MEM_WORDS;
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 16'h0;
    end else begin
      if (mem_we) mem[idx(mem_addr)] <= mem_wdata;
      mem_rdata <= mem[idx(mem_addr)];
    end
  end

  // Write-strobe monitor.
  int          we_count = 0;
  logic [15:0] we_addr = 16'h0;
  logic [15:0] we_data = 16'h0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count = we_count + 1;
      we_addr  = mem_addr;
      we_data  = mem_wdata;
    end
  end

  // Reference model.
  logic [15:0] ref_mem [MEM_WORDS];

  function automatic logic model_err(input logic wr, input logic [15:0] a, input logic [3:0] len);
    int last_word;
    last_word = int'(a) + int'(len);
    if (wr) return CHECK_EN && (int'(a) >= MEM_WORDS);
    return CHECK_EN && (last_word >= MEM_WORDS);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver and scoreboard for one request. stall_idx selects the response
  // word that is held off for stall_len cycles; -2 picks a random stall for
  // every word.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [3:0] len,
                        input logic [15:0] wd, input int stall_idx, input int stall_len);
    logic [17:0] exp_q[$];
    logic [17:0] e;
    logic [15:0] a;
    logic        err;
    int          n, cyc, stall, we0, first_lat;
    err = model_err(wr, addr, len);
    if (err) begin
      exp_q.push_back({1'b1, 1'b1, 16'h0000});
      first_lat = 1;
    end else if (wr) begin
      ref_mem[idx(addr)] = wd;
      exp_q.push_back({1'b0, 1'b1, wd});
      first_lat = 2;
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + 16'(i);
        exp_q.push_back({1'b0, (i == int'(len)), ref_mem[idx(a)]});
      end
      first_lat = 3;
    end

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wd;
    we0       = we_count;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    req_len   = 4'($urandom);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (rsp_valid !== 1'b1 && cyc < 100);
      check("rsp_latency", 32'(cyc), 32'((n == 0) ? first_lat : 3));
      if (rsp_valid !== 1'b1) return;
      check("req_ready_busy", 32'(req_ready), 32'd0);
      stall = (stall_idx == n) ? stall_len : ((stall_idx == -2) ? $urandom_range(0, 3) : 0);
      for (int s = 0; s < stall; s++) @(negedge clk);
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
      check("rsp_last", 32'(rsp_last), 32'(e[16]));
      check("rsp_err", 32'(rsp_err), 32'(e[17]));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      n++;
    end
    @(negedge clk);
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("mem_we_count", 32'(we_count - we0), 32'((wr && !err) ? 1 : 0));
    if (wr && !err) begin
      check("mem_we_addr", 32'(we_addr), 32'(addr));
      check("mem_we_data", 32'(we_data), 32'(wd));
      check("mem_word", 32'(mem[idx(addr)]), 32'(wd));
    end
  endtask

  // Directed and random sequence.
  initial begin
    logic [15:0] pre_data [4];
    logic        wr;
    logic [15:0] addr;
    int          sel;
    pre_data[0] = 16'h1111;
    pre_data[1] = 16'h2222;
    pre_data[2] = 16'h3333;
    pre_data[3] = 16'h4444;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 16'h0;

    // Reset values.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_clear = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write.
    do_req(1'b1, 16'h0010, 4'd0, 16'hBEEF, -1, 0);

    // Preload, then a 4-word burst without and with backpressure.
    for (int i = 0; i < 4; i++) do_req(1'b1, 16'h0020 + 16'(i), 4'd0, pre_data[i], -1, 0);
    do_req(1'b0, 16'h0020, 4'd3, 16'h0000, -1, 0);
    do_req(1'b0, 16'h0020, 4'd3, 16'h0000, 1, 5);

    // Reset in the WR cycle drops the write and the response.
    do_req(1'b1, 16'h0005, 4'd0, 16'h1234, -1, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0005;
    req_wdata = 16'hAAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_mem_word", 32'(mem[5]), 32'(ref_mem[5]));
    do_req(1'b0, 16'h0005, 4'd0, 16'h0000, -1, 0);

    // Top of the address range, plus 16-bit wrap.
    do_req(1'b1, 16'h3FFE, 4'd0, 16'hA001, -1, 0);
    do_req(1'b1, 16'h3FFF, 4'd0, 16'hA002, -1, 0);
    do_req(1'b1, 16'h0000, 4'd0, 16'hA003, -1, 0);
    do_req(1'b0, 16'h3FFE, 4'd2, 16'h0000, -1, 0);
    do_req(1'b0, 16'h3FFF, 4'd0, 16'h0000, -1, 0);
    do_req(1'b0, 16'h3FF0, 4'd15, 16'h0000, -1, 0);
    do_req(1'b0, 16'hFFFF, 4'd1, 16'h0000, -1, 0);
    do_req(1'b1, 16'h4000, 4'd0, 16'h5A5A, -1, 0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 40; k++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      if (sel == 0) addr = 16'($urandom_range(0, 63));
      else if (sel == 1) addr = 16'($urandom_range(MEM_WORDS - 20, MEM_WORDS - 1));
      else if (sel == 2) addr = 16'($urandom_range(0, 65535));
      else addr = 16'($urandom_range(0, MEM_WORDS - 1));
      do_req(wr, addr, 4'($urandom_range(0, 15)), 16'($urandom), -2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
